mem_port_arbiter: RTL and testbench

//  Shares the single synchronous instruction/data RAM port between fetch (IF) and the MEM stage (loads/stores).

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_tag_pipe.sv | 29 ++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data RAM port arbiter: owner tags, FSM states and the registered request.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } mem_owner_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_TURN = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Owner-tag shift register tracking which requester each in-flight RAM read belongs to.
// A flush retags every in-flight fetch slot as OWN_NONE while the incoming tag is kept.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  mem_owner_t tag_in,
  output mem_owner_t head
);

  mem_owner_t slot [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= OWN_NONE;
    end else begin
      slot[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++)
        slot[i] <= (flush && slot[i-1] == OWN_IF) ? OWN_NONE : slot[i-1];
    end
  end

  assign head = slot[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and the MEM stage; data accesses win.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int RAM_LAT    = 1,
  parameter int WR_BUBBLE  = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              fetch_stall
);

  arb_state_t state, state_nxt;
  mem_req_t   req_nxt;
  mem_owner_t tag_in, head;
  logic       force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] streak;

  assign force_if = (streak >= STARVE_LIM);

  // Counts data grants that overtook a waiting fetch; saturates at 7.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        streak <= '0;
    else if (!if_req_valid || if_req_ready) streak <= '0;
    else if (dm_req_ready && streak != 3'd7) streak <= streak + 3'd1;
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_req_ready  = 1'b0;
    dm_req_ready  = 1'b0;
    state_nxt     = state;
    req_nxt.we    = 1'b0;
    req_nxt.addr  = ram_addr;
    req_nxt.wdata = ram_wdata;
    tag_in        = OWN_NONE;
    case (state)
      S_RUN: begin
        if (dm_req_valid && !(force_if && if_req_valid)) begin
          dm_req_ready  = 1'b1;
          req_nxt.we    = dm_req_we;
          req_nxt.addr  = dm_req_addr;
          req_nxt.wdata = dm_req_wdata;
          tag_in        = dm_req_we ? OWN_NONE : OWN_DM;
          if (dm_req_we && WR_BUBBLE != 0) state_nxt = S_TURN;
        end else if (if_req_valid) begin
          if_req_ready = 1'b1;
          req_nxt.addr = if_req_addr;
          tag_in       = OWN_IF;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RUN;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      state     <= state_nxt;
      ram_addr  <= req_nxt.addr;
      ram_we    <= req_nxt.we;
      ram_wdata <= req_nxt.wdata;
    end
  end

  // Tag reaches the pipe head in the cycle the RAM presents its read data.
  mem_arb_tag_pipe #(.DEPTH(RAM_LAT + 1)) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (if_flush),
    .tag_in  (tag_in),
    .head    (head)
  );

  assign if_rsp_valid = (head == OWN_IF) && !if_flush;
  assign dm_rsp_valid = (head == OWN_DM);
  assign if_rsp_data  = ram_rd_data;
  assign dm_rsp_data  = ram_rd_data;
  assign fetch_stall  = if_req_valid && !if_req_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a RAM environment and a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LAT        = 2;
  localparam int BUBBLE     = 1;
  localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int NCYC = 8192;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req_valid = 1'b0, if_flush = 1'b0;
  logic [15:0] if_req_addr = '0;
  logic        if_req_ready, if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid = 1'b0, dm_req_we = 1'b0;
  logic [15:0] dm_req_addr = '0;
  logic [31:0] dm_req_wdata = '0;
  logic        dm_req_ready, dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata, ram_rd_data;
  logic        fetch_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(LAT), .WR_BUBBLE(BUBBLE), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready), .dm_rsp_valid(dm_rsp_valid),
    .dm_rsp_data(dm_rsp_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rd_data(ram_rd_data), .fetch_stall(fetch_stall)
  );

  function automatic logic [31:0] init_val(input int a);
    logic [15:0] lo;
    lo = a[15:0];
    return {lo ^ 16'hC0DE, lo};
  endfunction

  // Synchronous RAM environment: address in cycle N+1, data in cycle N+1+LAT.
  logic [31:0] ram [0:65535];
  logic [31:0] rd_pipe [LAT];
  initial for (int a = 0; a < 65536; a++) ram[a] = init_val(a);
  always @(posedge clk) begin
    rd_pipe[0] <= ram[ram_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end
  assign ram_rd_data = rd_pipe[LAT-1];

  // Reference model: memory image plus expected response owner/data per cycle.
  logic [31:0] mm [int];
  int          exp_own [NCYC];   // 0 none, 1 fetch, 2 data
  logic [31:0] exp_dat [NCYC];
  int          cyc = 0;
  bit          m_turn = 1'b0;
  int          m_streak = 0;
  bit          m_we_prev = 1'b0;
  int          n_checks = 0, n_errors = 0;

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : init_val(int'(a));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] ia, input logic fl,
                      input logic dv, input logic we, input logic [15:0] da, input logic [31:0] wd);
    bit m_dm, m_if;
    int eo;
    @(negedge clk);
    if_req_valid = iv; if_req_addr = ia; if_flush = fl;
    dm_req_valid = dv; dm_req_we = we; dm_req_addr = da; dm_req_wdata = wd;
    #1;
    m_dm = !m_turn && dv && !(GUARD && m_streak >= STARVE_MAX && iv);
    m_if = !m_turn && iv && !m_dm;
    check("dm_req_ready", 32'(dm_req_ready), 32'(m_dm));
    check("if_req_ready", 32'(if_req_ready), 32'(m_if));
    check("fetch_stall", 32'(fetch_stall), 32'(iv && !m_if));
    check("ram_we", 32'(ram_we), 32'(m_we_prev));
    eo = exp_own[cyc];
    if (fl && eo == 1) eo = 0;
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(eo == 1));
    check("dm_rsp_valid", 32'(dm_rsp_valid), 32'(eo == 2));
    if (eo == 1) check("if_rsp_data", if_rsp_data, exp_dat[cyc]);
    if (eo == 2) check("dm_rsp_data", dm_rsp_data, exp_dat[cyc]);
    if (fl)
      for (int d = cyc + 1; d <= cyc + LAT; d++) if (exp_own[d] == 1) exp_own[d] = 0;
    m_we_prev = m_dm && we;
    if (m_dm) begin
      if (we) mm[int'(da)] = wd;
      else begin exp_own[cyc+LAT+1] = 2; exp_dat[cyc+LAT+1] = mem_rd(da); end
    end
    if (m_if) begin exp_own[cyc+LAT+1] = 1; exp_dat[cyc+LAT+1] = mem_rd(ia); end
    m_turn = !m_turn && m_dm && we && (BUBBLE != 0);
    if (!iv || m_if) m_streak = 0;
    else if (m_dm && m_streak < 7) m_streak++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0, 0, 16'h0, 32'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_if_rsp_valid", 32'(if_rsp_valid), 32'h0);
    check("rst_dm_rsp_valid", 32'(dm_rsp_valid), 32'h0);
    check("rst_readies", 32'({if_req_ready, dm_req_ready}), 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    if_req_valid = 0; if_flush = 0; dm_req_valid = 0; dm_req_we = 0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int d = cyc; d < NCYC; d++) exp_own[d] = 0;
    m_turn = 0; m_streak = 0; m_we_prev = 0;
  endtask

  int first_if;

  initial begin
    for (int d = 0; d < NCYC; d++) begin exp_own[d] = 0; exp_dat[d] = '0; end
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;

    // Fetch-only stream
    for (int i = 0; i < 3; i++) step(1, 16'(i), 0, 0, 0, 16'h0, 32'h0);
    idle(4);
    // Collision: load wins, fetch follows
    step(1, 16'h0010, 0, 1, 0, 16'h0200, 32'h0);
    step(1, 16'h0010, 0, 0, 0, 16'h0, 32'h0);
    idle(4);
    // Store, bubble, load of the same word
    step(0, 16'h0, 0, 1, 1, 16'h0040, 32'hDEADBEEF);
    step(0, 16'h0, 0, 1, 0, 16'h0040, 32'h0);
    step(0, 16'h0, 0, 1, 0, 16'h0040, 32'h0);
    idle(4);
    // Flush with three fetches in flight
    for (int i = 0; i < 3; i++) step(1, 16'h0020 + 16'(i), 0, 0, 0, 16'h0, 32'h0);
    step(1, 16'h0100, 1, 0, 0, 16'h0, 32'h0);
    idle(4);
    // Flush with a load in flight
    step(1, 16'h0030, 0, 0, 0, 16'h0, 32'h0);
    step(0, 16'h0, 0, 1, 0, 16'h0041, 32'h0);
    step(1, 16'h0031, 0, 0, 0, 16'h0, 32'h0);
    step(1, 16'h0100, 1, 0, 0, 16'h0, 32'h0);
    idle(5);
    // Reset while two loads are pending
    step(0, 16'h0, 0, 1, 0, 16'h0005, 32'h0);
    step(0, 16'h0, 0, 1, 0, 16'h0006, 32'h0);
    apply_reset();
    idle(5);
    // Data requests held for ten cycles with a fetch waiting
    first_if = 0;
    for (int k = 1; k <= 12; k++) begin
      step(first_if == 0, 16'h0050, 0, k <= 10, 0, 16'(16'h0060 + k), 32'h0);
      if (if_req_ready && first_if == 0) first_if = k;
    end
    check("starve_first_fetch_grant", 32'(first_if), GUARD ? 32'(STARVE_MAX + 1) : 32'd11);
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic iv, fl, dv, we;
      iv = ($urandom_range(0, 99) < 60);
      dv = ($urandom_range(0, 99) < 50);
      we = ($urandom_range(0, 99) < 30);
      fl = ($urandom_range(0, 99) < 5);
      step(iv, 16'($urandom_range(0, 63)), fl, dv, we, 16'($urandom_range(0, 63)), $urandom);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
